// File: rtl/multiword_add_ctrl.sv
// ----------------------------------------------------------------------------
// multiword_add_ctrl
//
// Performs a WIDTH*WORDS-bit addition {cout,sum} = a + b + cin by stepping a
// single WIDTH-bit param_full_adder across the operands, one word per clock,
// least significant word first. The carry between words lives in a register.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, only looked at while idle
//   a, b   : WIDTH*WORDS-bit operands, captured when start is accepted
//   cin    : carry-in, captured when start is accepted
//   busy   : high while an operation is running or reporting its result
//   done   : one-cycle pulse when sum/cout hold the finished result
//   sum    : result, held until the next accepted start
//   cout   : final carry-out, same validity as sum
//
// param_full_adder is the shared narrow datapath: a plain WIDTH-bit adder
// with carry in and carry out.
// ----------------------------------------------------------------------------

module param_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Zero-extend by one bit so the top bit of the addition is the carry.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

module multiword_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout
);

    localparam int TOTAL = WIDTH * WORDS;
    // One spare bit so the word index never has to wrap, even at WORDS=256.
    localparam int IDX_W = $clog2((WORDS > 1) ? WORDS : 2) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TOTAL-1:0]   a_q, a_d;
    logic [TOTAL-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TOTAL-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // The adder only ever sees registered operands, so there is no
    // combinational path from the a/b/cin ports to sum/cout.
    always_comb begin
        add_a = a_q[idx_q*WIDTH +: WIDTH];
        add_b = b_q[idx_q*WIDTH +: WIDTH];
    end

    param_full_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state logic. sum is cleared on acceptance so stale words from the
    // previous operation never mix with the new partial result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                sum_d[idx_q*WIDTH +: WIDTH] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multiword_add_ctrl
//
// Three instances of multiword_add_ctrl share one clock and reset:
//   inst0 : WIDTH=8, WORDS=4  (32-bit operands)
//   inst1 : WIDTH=4, WORDS=3  (12-bit operands)
//   inst2 : WIDTH=8, WORDS=1  (8-bit operands)
// A behavioural model tracks, per instance, how many cycles have passed since
// an operation was accepted and what a + b + cin must be, and a compare
// process checks busy/done/result against it on every falling edge.
// Directed scenarios add literal expectations on top of that.
// ----------------------------------------------------------------------------

module tb_multiword_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    logic [2:0]  start_v = '0;
    logic [2:0]  cin_v   = '0;
    logic [31:0] a_s [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] b_s [3] = '{32'd0, 32'd0, 32'd0};
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [31:0] sum0;
    logic [11:0] sum1;
    logic [7:0]  sum2;
    logic        cout0, cout1, cout2;
    logic [32:0] res_s [3];

    int words [3] = '{4, 3, 1};
    int wtot  [3] = '{32, 12, 8};

    int n_compared   = 0;
    int n_mismatched = 0;

    multiword_add_ctrl #(.WIDTH(8), .WORDS(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout0)
    );

    multiword_add_ctrl #(.WIDTH(4), .WORDS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_s[1][11:0]), .b(b_s[1][11:0]), .cin(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout1)
    );

    multiword_add_ctrl #(.WIDTH(8), .WORDS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .cin(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout2)
    );

    always_comb begin
        res_s[0] = 33'({cout0, sum0});
        res_s[1] = 33'({cout1, sum1});
        res_s[2] = 33'({cout2, sum2});
    end

    // Exact reference sum for an instance, operands truncated to its width.
    function automatic logic [32:0] refSum(input int i, input logic [31:0] av,
                                           input logic [31:0] bv, input logic cv);
        logic [32:0] mask;
        mask = (33'd1 << wtot[i]) - 33'd1;
        return (33'(av) & mask) + (33'(bv) & mask) + 33'(cv);
    endfunction

    task automatic checkOutput(input string name, input logic [32:0] got,
                               input logic [32:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Behavioural model: age counts cycles since acceptance (0 = idle);
    // the operation reports its result when age reaches words+1.
    int          age    [3];
    logic [32:0] pend   [3];
    logic [32:0] expres [3];
    bit          rvalid [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            age[i] = 0; pend[i] = '0; expres[i] = '0; rvalid[i] = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                age[i] = 0; expres[i] = '0; rvalid[i] = 1'b1;
            end else if (age[i] == 0) begin
                if (start_v[i]) begin
                    pend[i]   = refSum(i, a_s[i], b_s[i], cin_v[i]);
                    age[i]    = 1;
                    rvalid[i] = 1'b0;
                end
            end else if (age[i] == words[i] + 1) begin
                age[i] = 0;
            end else begin
                age[i]++;
                if (age[i] == words[i] + 1) begin
                    expres[i] = pend[i];
                    rvalid[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("model busy inst%0d", i), 33'(busy_v[i]), 33'(age[i] != 0));
            checkOutput($sformatf("model done inst%0d", i), 33'(done_v[i]),
                        33'(age[i] == words[i] + 1));
            if (rvalid[i])
                checkOutput($sformatf("model result inst%0d", i), res_s[i], expres[i]);
        end
    end

    task automatic waitIdle(input int i);
        int g;
        g = 0;
        @(negedge clk);
        while (busy_v[i] && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL idle timeout inst%0d: busy still %0b after %0d cycles", i, busy_v[i], g);
        end
    endtask

    // Issue one operation on instance i, return edges-to-done and the result.
    task automatic applyStimulus(input int i, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, output int lat, output logic [32:0] res);
        waitIdle(i);
        start_v[i] = 1'b1;
        a_s[i]     = av;
        b_s[i]     = bv;
        cin_v[i]   = cv;
        @(posedge clk);
        @(negedge clk);
        start_v[i] = 1'b0;
        a_s[i]     = $urandom;
        b_s[i]     = $urandom;
        cin_v[i]   = 1'($urandom_range(0, 1));
        lat = 0;
        while (!done_v[i] && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = res_s[i];
    endtask

    initial begin : stim
        int          lat;
        logic [32:0] res;
        int          done_at[$];
        logic [31:0] av, bv;
        logic        cv;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 33'(busy_v[0]), 33'd0);
        checkOutput("reset done", 33'(done_v[0]), 33'd0);
        checkOutput("reset result", res_s[0], 33'd0);
        rst_n = 1'b1;

        // Carry ripples through every word.
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, res);
        checkOutput("ripple latency", 33'(lat), 33'd4);
        checkOutput("ripple result", res, 33'h1_0000_0000);

        applyStimulus(0, 32'h1234_5678, 32'h0000_0000, 1'b1, lat, res);
        checkOutput("cin result", res, 33'h0_1234_5679);

        applyStimulus(2, 32'h0000_00FF, 32'h0000_00FF, 1'b1, lat, res);
        checkOutput("words1 latency", 33'(lat), 33'd1);
        checkOutput("words1 result", res, 33'h0_0000_01FF);

        applyStimulus(1, 32'h0000_0FFF, 32'h0000_0001, 1'b1, lat, res);
        checkOutput("w4n3 latency", 33'(lat), 33'd3);
        checkOutput("w4n3 result", res, 33'h0_0000_1001);

        // A start pulse during RUN must not disturb the running operation.
        waitIdle(0);
        start_v[0] = 1'b1; a_s[0] = 32'h1234_5678; b_s[0] = 32'h1111_1111; cin_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1; a_s[0] = 32'hFFFF_FFFF; b_s[0] = 32'hFFFF_FFFF; cin_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 0;
        while (!done_v[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("reject result", res_s[0], 33'h0_2345_6789);
        repeat (3) @(negedge clk);
        checkOutput("reject no rerun", 33'(busy_v[0]), 33'd0);

        // start held high: a done pulse every WORDS+2 cycles.
        waitIdle(0);
        start_v[0] = 1'b1; a_s[0] = 32'h0000_0010; b_s[0] = 32'h0000_0020; cin_v[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done_v[0]) done_at.push_back(k);
        end
        start_v[0] = 1'b0;
        checkOutput("held done count", 33'(done_at.size()), 33'd5);
        for (int j = 0; j < done_at.size() && j < 5; j++)
            checkOutput($sformatf("held done slot %0d", j), 33'(done_at[j]), 33'(5 + 6 * j));

        // Reset in the middle of an operation.
        waitIdle(0);
        start_v[0] = 1'b1; a_s[0] = 32'hDEAD_BEEF; b_s[0] = 32'h0101_0101; cin_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun reset busy", 33'(busy_v[0]), 33'd0);
        checkOutput("midrun reset done", 33'(done_v[0]), 33'd0);
        checkOutput("midrun reset result", res_s[0], 33'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 32'd1, 32'd1, 1'b0, lat, res);
        checkOutput("after reset latency", 33'(lat), 33'd4);
        checkOutput("after reset result", res, 33'd2);

        // Random regression on both multi-word configurations.
        for (int n = 0; n < 200; n++) begin
            int i;
            i  = n % 2;
            av = $urandom;
            bv = $urandom;
            cv = 1'($urandom_range(0, 1));
            applyStimulus(i, av, bv, cv, lat, res);
            checkOutput($sformatf("rand %0d latency", n), 33'(lat), 33'(words[i]));
            checkOutput($sformatf("rand %0d result", n), res, refSum(i, av, bv, cv));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
